hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Parametrised successor of the pipeline load-use hazard detector.
- Tracks in-flight loads in a small shift-register scoreboard, so a load result that stays unforwardable for LOAD_LAT cycles stalls dependent instructions for the right number of cycles.
- Keeps branch-flush priority.
- Sits beside the ID stage. Drives PC write enable, IF/ID write enable and the IF/ID, ID/EX and EX/MEM flush controls.

Parameters:
- REG_AW, 5, register-address width.
- OP_W, 6, opcode width.
- LOAD_LAT, 2, number of cycles (counted from the load's EX cycle) during which a dependent instruction in ID must stall; legal range 1..8.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-low reset.
- MemRead_idex  in  1  instruction currently in EX is a load.
- rt_idex  in  REG_AW  destination register of the load in EX.
- op  in  OP_W  opcode of the instruction in ID.
- rs  in  REG_AW  rs field of the instruction in ID.
- rt  in  REG_AW  rt field of the instruction in ID.
- branch  in  1  taken branch resolved this cycle.
- PCWrite  out  1  PC write enable.
- write_ifid  out  1  IF/ID write enable.
- flush_ifid  out  1  flush IF/ID.
- flush_idex  out  1  flush ID/EX (inserts a bubble).
- flush_exmem  out  1  flush EX/MEM.

Behaviour:
- Scoreboard slots 0..LOAD_LAT-1, each holding {valid, dest[REG_AW-1:0]}.
  - Slot 0 is combinational: valid = MemRead_idex && (rt_idex != 0), dest = rt_idex.
  - Slots 1..LOAD_LAT-1 are registers.
  - LOAD_LAT=1 means no registered slots; behaviour is then purely combinational.
- Shift on every rising edge with rst_i=1: slot[k] <= slot[k-1] for k>=1.
  - The shift happens regardless of stall, because loads in EX and later stages always advance.
  - When branch=1, slot[1] loads invalid (the EX-stage instruction is squashed). Slots k>=2 still shift normally.
- Source use rules:
  - rs is a source when rs != 0.
  - rt is a source only when rt != 0 and op is one of 000000 (R-type), 000100 (beq), 000101 (bne), 101011 (sw).
  - All other opcodes (addi, addiu, slti, sltiu, andi, ori, lui, lw, ...) never hazard on rt.
- hazard = any valid slot whose dest equals a source register of the instruction in ID.
- Output encoding {PCWrite, write_ifid, flush_ifid, flush_idex, flush_exmem}, combinational, in priority order:
  - rst_i=0: 11000.
  - branch=1: 11111. Branch overrides hazard.
  - hazard=1: 00010 (freeze PC and IF/ID, bubble ID/EX).
  - otherwise: 11000.
- Stall length: a dependent instruction stalls exactly (LOAD_LAT - d) cycles, where d is the number of cycles the load is already past EX when the dependent instruction reaches ID.
  - Back-to-back lw -> use with LOAD_LAT=2 gives 2 stall cycles.
  - A bubble inserted by a stall enters slot 0 as invalid on the following cycle, because MemRead_idex=0.
- Multiple matching loads: stall lasts until no valid slot matches.
- Reset (rst_i=0 at a rising edge) invalidates all registered slots.
  - Reset asserted mid-stall releases the stall from the next cycle, unless slot 0 still matches.
  - Outputs read 11000 for the whole time rst_i=0.
- No X propagation: all registered slots have defined reset values (valid=0, dest=0).

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three ports:
  - stall_cnt_o  out  16: counts cycles with hazard output 00010.
  - flush_cnt_o  out  16: counts cycles with branch=1.
  - stats_clr_i  in  1: synchronous clear, higher priority than increment.
- Both counters:
  - reset to 0 on rst_i=0;
  - saturate at 16'hFFFF.
- When the macro is not defined, these ports and counters do not exist. The core behaviour is identical in both builds.

Test Plan:
- LOAD_LAT=2. Cycle 0: MemRead_idex=1, rt_idex=8. ID holds op=000000, rs=8, rt=9.
  - Required: outputs 00010 in cycles 0 and 1, then 11000 in cycle 2.
- LOAD_LAT=2. Load to $8 in EX. ID holds op=001000 (addi), rs=3, rt=8.
  - Required: 11000, no stall.
  - Repeat with op=101011 (sw), rt=8: required 00010 for 2 cycles.
- Load to $0 in EX. ID holds rs=0, op=000000, rt=0.
  - Required: 11000. Register zero never hazards.
- LOAD_LAT=2. Load to $8 in EX, branch=1 in the same cycle, ID holds rs=8.
  - Required: 11111 in that cycle.
  - Next cycle, with MemRead_idex=0 and ID rs=8: 11000, because slot 1 was squashed.
- LOAD_LAT=3. Load to $5 in EX at cycle 0. rst_i=0 at cycle 1, rst_i=1 from cycle 2. ID rs=5 throughout, MemRead_idex=0 after cycle 0.
  - Required: 00010 at cycle 0, 11000 at cycles 1 and 2 (slots cleared).
- HAZARD_STATS_EN build: after the first scenario followed by one branch:
  - Required: stall_cnt_o=2, flush_cnt_o=1.
  - Pulse stats_clr_i: both counters read 0 the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard detector with a LOAD_LAT-deep shift-register scoreboard of in-flight loads.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush counters with a synchronous clear.
module hazard_scoreboard_unit #(
  parameter int REG_AW   = 5,
  parameter int OP_W     = 6,
  parameter int LOAD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_idex,
  input  logic [REG_AW-1:0] rt_idex,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              branch,
  output logic              PCWrite,
  output logic              write_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem
`ifdef HAZARD_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  // reg_* index k holds scoreboard slot k+1; sized to at least 1 so LOAD_LAT=1 stays legal.
  localparam int NREG = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  logic                       slot0_valid;
  logic [REG_AW-1:0]          slot0_dest;
  logic [NREG-1:0]            reg_valid;
  logic [NREG-1:0][REG_AW-1:0] reg_dest;
  logic                       rs_src;
  logic                       rt_src;
  logic                       hazard;
  logic [4:0]                 ctrl;

  assign slot0_valid = MemRead_idex && (rt_idex != '0);
  assign slot0_dest  = rt_idex;

  assign rs_src = (rs != '0);
  assign rt_src = (rt != '0) &&
                  ((op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW));

  generate
    if (LOAD_LAT > 1) begin : g_slots
      // Shifts even while stalling: loads in EX and beyond always advance down the pipe.
      always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every slot samples its neighbour's pre-edge value.
        if (!rst_i) begin
          // NOTE: scoreboard slots are few flops, so all are reset to avoid X in the hazard compare.
          reg_valid <= '0;
          reg_dest  <= '0;
        end else begin
          reg_valid[0] <= slot0_valid && !branch;
          reg_dest[0]  <= slot0_dest;
          for (int k = 1; k < NREG; k++) begin
            reg_valid[k] <= reg_valid[k-1];
            reg_dest[k]  <= reg_dest[k-1];
          end
        end
      end
    end else begin : g_no_slots
      assign reg_valid = '0;
      assign reg_dest  = '0;
    end
  endgenerate

  always_comb begin
    // NOTE: default assigned first so no path through the loop can infer a latch.
    hazard = slot0_valid &&
             ((rs_src && (slot0_dest == rs)) || (rt_src && (slot0_dest == rt)));
    for (int k = 0; k < NREG; k++) begin
      if (reg_valid[k] &&
          ((rs_src && (reg_dest[k] == rs)) || (rt_src && (reg_dest[k] == rt))))
        hazard = 1'b1;
    end
  end

  // {PCWrite, write_ifid, flush_ifid, flush_idex, flush_exmem}; branch wins over hazard.
  always_comb begin
    ctrl = 5'b11000;
    if (rst_i) begin
      if (branch)      ctrl = 5'b11111;
      else if (hazard) ctrl = 5'b00010;
    end
  end

  assign {PCWrite, write_ifid, flush_ifid, flush_idex, flush_exmem} = ctrl;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i || stats_clr_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!branch && hazard && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
      if (branch && (flush_cnt_o != 16'hFFFF))            flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: LOAD_LAT=2 and LOAD_LAT=3 instances share stimulus; expectations
// come from a load-log model and test-plan constants, queued at drive time and popped at sampling.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read;
  logic [4:0] rt_ex;
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       branch;
  logic [4:0] out2, out3;
`ifdef HAZARD_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_cnt2, flush_cnt2, stall_cnt3, flush_cnt3;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(5), .OP_W(6), .LOAD_LAT(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_idex(mem_read), .rt_idex(rt_ex),
    .op(op), .rs(rs), .rt(rt), .branch(branch),
    .PCWrite(out2[4]), .write_ifid(out2[3]), .flush_ifid(out2[2]),
    .flush_idex(out2[1]), .flush_exmem(out2[0])
`ifdef HAZARD_STATS_EN
    , .stats_clr_i(stats_clr), .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
`endif
  );

  hazard_scoreboard_unit #(.REG_AW(5), .OP_W(6), .LOAD_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_idex(mem_read), .rt_idex(rt_ex),
    .op(op), .rs(rs), .rt(rt), .branch(branch),
    .PCWrite(out3[4]), .write_ifid(out3[3]), .flush_ifid(out3[2]),
    .flush_idex(out3[1]), .flush_exmem(out3[0])
`ifdef HAZARD_STATS_EN
    , .stats_clr_i(stats_clr), .stall_cnt_o(stall_cnt3), .flush_cnt_o(flush_cnt3)
`endif
  );

  typedef struct {
    string      tag;
    int         lat;
    logic [4:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ld_dest[$];
  int   ld_time[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic bit uses(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                              input int dest);
    bit t_src;
    t_src = (t != 0) && (o == 6'd0 || o == 6'd4 || o == 6'd5 || o == 6'd43);
    return (dest != 0) && (((s != 0) && (dest == s)) || (t_src && (dest == t)));
  endfunction

  // Hazard if the load now in EX, or any unsquashed load issued fewer than lat cycles ago, matches.
  function automatic logic [4:0] model_out(input int lat);
    bit hz;
    hz = mem_read && uses(op, rs, rt, int'(rt_ex));
    foreach (ld_dest[i])
      if ((cyc - ld_time[i] < lat) && uses(op, rs, rt, ld_dest[i])) hz = 1'b1;
    if (!rst_n)      return 5'b11000;
    else if (branch) return 5'b11111;
    else if (hz)     return 5'b00010;
    else             return 5'b11000;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      ld_dest.delete();
      ld_time.delete();
    end else if (mem_read && rt_ex != 0 && !branch) begin
      ld_dest.push_back(int'(rt_ex));
      ld_time.push_back(cyc);
    end
    while (ld_time.size() > 0 && cyc - ld_time[0] >= 8) begin
      void'(ld_time.pop_front());
      void'(ld_dest.pop_front());
    end
    cyc++;
  endtask

  // One cycle: drive, queue expectations (want < 0 means no test-plan constant), sample, clock.
  task automatic step(input string tag, input logic rn, input logic mr, input logic [4:0] rx,
                      input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic br, input int want2, input int want3);
    exp_t e;
    rst_n = rn; mem_read = mr; rt_ex = rx; op = o; rs = s; rt = t; branch = br;
    e.tag = {tag, "/model2"}; e.lat = 2; e.exp = model_out(2); q.push_back(e);
    e.tag = {tag, "/model3"}; e.lat = 3; e.exp = model_out(3); q.push_back(e);
    if (want2 >= 0) begin
      e.tag = {tag, "/plan2"}; e.lat = 2; e.exp = 5'(want2); q.push_back(e);
    end
    if (want3 >= 0) begin
      e.tag = {tag, "/plan3"}; e.lat = 3; e.exp = 5'(want3); q.push_back(e);
    end
    #4;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {11'd0, (e.lat == 2) ? out2 : out3}, {11'd0, e.exp});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1, 0, 0, 6'd0, 0, 0, 0, 5'b11000, 5'b11000);
  endtask

  localparam int STALL = 5'b00010;
  localparam int RUN   = 5'b11000;
  localparam int FLUSH = 5'b11111;

  initial begin
    rst_n = 0; mem_read = 0; rt_ex = 0; op = 0; rs = 0; rt = 0; branch = 0;
`ifdef HAZARD_STATS_EN
    stats_clr = 0;
`endif
    @(posedge clk); #1;
    step("reset", 0, 0, 0, 6'd0, 0, 0, 0, RUN, RUN);

    // Back-to-back lw $8 -> R-type using $8: two stall cycles at LOAD_LAT=2.
    step("lu_c0", 1, 1, 8, 6'd0, 8, 9, 0, STALL, STALL);
    step("lu_c1", 1, 0, 0, 6'd0, 8, 9, 0, STALL, STALL);
    step("lu_c2", 1, 0, 0, 6'd0, 8, 9, 0, RUN, STALL);
    step("lu_c3", 1, 0, 0, 6'd0, 8, 9, 0, RUN, RUN);
    step("br_one", 1, 0, 0, 6'd0, 0, 0, 1, FLUSH, FLUSH);
`ifdef HAZARD_STATS_EN
    check("stall_cnt", stall_cnt2, 16'd2);
    check("flush_cnt", flush_cnt2, 16'd1);
    check("stall_cnt3", stall_cnt3, 16'd3);
    stats_clr = 1;
    step("clr", 1, 0, 0, 6'd0, 0, 0, 0, RUN, RUN);
    stats_clr = 0;
    check("stall_clr", stall_cnt2, 16'd0);
    check("flush_clr", flush_cnt2, 16'd0);
`endif
    idle(3);

    // addi never reads rt; sw does.
    step("addi_c0", 1, 1, 8, 6'b001000, 3, 8, 0, RUN, RUN);
    step("addi_c1", 1, 0, 0, 6'b001000, 3, 8, 0, RUN, RUN);
    idle(3);
    step("sw_c0", 1, 1, 8, 6'b101011, 3, 8, 0, STALL, STALL);
    step("sw_c1", 1, 0, 0, 6'b101011, 3, 8, 0, STALL, STALL);
    step("sw_c2", 1, 0, 0, 6'b101011, 3, 8, 0, RUN, -1);
    idle(3);

    // Register zero never hazards.
    step("zero_c0", 1, 1, 0, 6'd0, 0, 0, 0, RUN, RUN);
    step("zero_c1", 1, 0, 0, 6'd0, 0, 0, 0, RUN, RUN);
    idle(3);

    // Branch in the load's EX cycle: flush now, squashed load cannot stall later.
    step("br_c0", 1, 1, 8, 6'd0, 8, 0, 1, FLUSH, FLUSH);
    step("br_c1", 1, 0, 0, 6'd0, 8, 0, 0, RUN, RUN);
    step("br_c2", 1, 0, 0, 6'd0, 8, 0, 0, RUN, RUN);
    idle(3);

    // Reset mid-stall clears registered slots.
    step("rst_c0", 1, 1, 5, 6'd0, 5, 0, 0, -1, STALL);
    step("rst_c1", 0, 0, 0, 6'd0, 5, 0, 0, RUN, RUN);
    step("rst_c2", 1, 0, 0, 6'd0, 5, 0, 0, RUN, RUN);
    idle(3);

    // Two loads to the same register: stall until the younger one drains.
    step("multi_c0", 1, 1, 4, 6'd0, 0, 0, 0, RUN, RUN);
    step("multi_c1", 1, 1, 4, 6'd0, 4, 0, 0, STALL, STALL);
    step("multi_c2", 1, 0, 0, 6'd0, 4, 0, 0, STALL, STALL);
    step("multi_c3", 1, 0, 0, 6'd0, 4, 0, 0, RUN, STALL);
    idle(3);

    // Mixed random traffic over a small register range, checked against the model only.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] ops [6];
      ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd8, 6'd35};
      step("rand", ($urandom_range(19) != 0), 1'($urandom_range(1)), 5'($urandom_range(3)),
           ops[$urandom_range(5)], 5'($urandom_range(3)), 5'($urandom_range(3)),
           ($urandom_range(9) == 0), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
